f7_bias_loader: RTL and testbench
=================================

# f7_bias_loader

Sequencer that fetches the NUM output-layer (f7) bias words from the bias memory and streams them, one per output neuron, to the f7 bias buffer / accumulator stage over a valid/ready handshake. It sits between the on-chip bias memory, a single-port synchronous read port with fixed latency, and the f7 bias consumer. It is started once per inference by the layer controller and reports busy/done back to it.

## Interface
Parameters:
- WD, 8, bias word width (bits)
- NUM, 10, number of bias words per run (output neurons), 1..255
- AW, 8, bias memory address width
- BASE, 0, memory address of bias word 0
- RD_LAT, 1, memory read latency in cycles, 1..4

Ports:
- i_sclk  in  1  clock, all logic on rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse from layer controller
- i_clear  in  1  synchronous abort, returns to IDLE
- o_busy  out  1  high from first cycle after accepted start until DONE exits
- o_done  out  1  one-cycle pulse after the last transfer
- o_rd_en  out  1  memory read strobe
- o_rd_addr  out  AW  memory read address
- i_rd_data  in  WD  memory read data, valid RD_LAT cycles after o_rd_en
- o_bias_en  out  1  bias valid to consumer
- i_ready  in  1  consumer ready
- o_b_num  out  8  1-based neuron index of the presented bias (1..NUM)
- o_bias  out  WD  bias word
- i_shift  in  3  bias left-shift amount (used only with F7_BIAS_SHIFT_EN)

## Operation
- Reset values: state IDLE, index 0, o_busy 0, o_done 0, o_rd_en 0, o_rd_addr 0, o_bias_en 0, o_b_num 0, o_bias 0.
- FSM states: IDLE, RD, WAIT, VLD, DONE.
- IDLE: i_start=1 -> RD, index cleared to 0. i_start while not IDLE ignored.
- RD (1 cycle): o_rd_en=1, o_rd_addr=BASE+index (AW-bit wrap) -> WAIT.
- WAIT (RD_LAT cycles, latency counter): i_rd_data registered on the last WAIT cycle -> VLD.
- VLD: o_bias_en=1, o_bias = held word, o_b_num=index+1; both stable until transfer. Transfer = o_bias_en & i_ready. On transfer: index==NUM-1 -> DONE, else index+1 and -> RD.
- DONE (1 cycle): o_done=1 -> IDLE.
- o_bias_en, o_rd_en, o_done are decoded from registered state only. No combinational path from i_ready to any output.
- i_clear: in any state, next state IDLE, index 0, held word cleared. i_clear has priority over i_start and over a same-cycle transfer, and no o_done is issued. A read in flight is discarded.
- o_b_num is 0 outside VLD.

## Timing
- Start sampled at edge k -> RD in cycle k+1 -> WAIT cycles k+2..k+1+RD_LAT -> VLD from cycle k+2+RD_LAT.
- Per-bias cost with i_ready held high: 2+RD_LAT cycles. A full run with NUM=10 and RD_LAT=1 takes 30 cycles, with o_done in cycle k+31.
- Stall: VLD holds any number of cycles with outputs unchanged.
- o_busy=1 from cycle k+1 through the DONE cycle inclusive.

## Configuration
- F7_BIAS_SHIFT_EN defined: o_bias = i_rd_data (signed) << i_shift, saturated to the signed WD range (max 2^(WD-1)-1, min -2^(WD-1)). The shift and saturation are applied when the word is captured. i_shift must be stable while busy.
- F7_BIAS_SHIFT_EN undefined: o_bias = captured i_rd_data unchanged. i_shift is ignored.

## Structure
- Shared package: FSM state encoding (IDLE, RD, WAIT, VLD, DONE) and a signed saturating-shift function usable by other layer loaders.
- One sub-module: f7_bias_sat, the shift/saturate stage. It is instantiated only under F7_BIAS_SHIFT_EN.

## Test plan
- Reset, then start with memory holding 1..10 at BASE=0, i_ready=1 -> 10 transfers, bias values 1..10, o_b_num 1..10, each transfer 3 cycles apart, o_done 31 cycles after start.
- i_ready low for 5 cycles during neuron 4 -> o_bias_en, o_bias=4 and o_b_num=4 held for 5 cycles, no extra memory reads, final bias still 10.
- i_clear asserted in the WAIT state of neuron 6 -> IDLE next cycle, no o_done. A new start restarts from address BASE with o_b_num=1.
- i_start pulsed mid-run and asserted in the same cycle as i_clear -> the mid-run start is ignored, and after the clear the run does not start until a further start.
- RD_LAT=3 -> 5 cycles per bias, data never sampled early.
- With F7_BIAS_SHIFT_EN, WD=8, i_shift=2: word 20 -> 80, 40 -> 127, -40 -> -128, -3 -> -12.

Source files
------------

// File: rtl/f7_bias_loader_pkg.sv
// Shared definitions for the output-layer bias loaders: FSM encoding and
// a signed saturating left-shift that other layer loaders can reuse.
package f7_bias_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_VLD  = 3'd3,
        ST_DONE = 3'd4
    } f7_state_e;

    // Shift a sign-extended word left and clamp it to a signed wd-bit range.
    // The 40-bit intermediate holds the largest shifted value without overflow.
    function automatic logic signed [31:0] sat_shl(input logic signed [31:0] val,
                                                   input logic [2:0]         sh,
                                                   input int                 wd);
        logic signed [39:0] wide;
        logic signed [39:0] hi;
        logic signed [39:0] lo;
        wide = 40'(val) <<< sh;
        hi   = (40'sd1 <<< (wd - 1)) - 40'sd1;
        lo   = -(40'sd1 <<< (wd - 1));
        if (wide > hi) begin
            wide = hi;
        end else if (wide < lo) begin
            wide = lo;
        end
        return wide[31:0];
    endfunction

endpackage

// File: rtl/f7_bias_loader_if.sv
// Bias memory read port and bias stream towards the f7 accumulator stage.
interface f7_bias_loader_if #(
    parameter int WD = 8,
    parameter int AW = 8
);
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [WD-1:0] i_rd_data;
    logic          o_bias_en;
    logic          i_ready;
    logic [7:0]    o_b_num;
    logic [WD-1:0] o_bias;

    modport master (
        output o_rd_en, o_rd_addr, o_bias_en, o_b_num, o_bias,
        input  i_rd_data, i_ready
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_bias_en, o_b_num, o_bias,
        output i_rd_data, i_ready
    );
endinterface

// File: rtl/f7_bias_sat.sv
// Shift/saturate stage applied to a bias word as it is captured from memory.
module f7_bias_sat
    import f7_bias_loader_pkg::*;
#(
    parameter int WD = 8
) (
    input  logic [WD-1:0] din,
    input  logic [2:0]    sh,
    output logic [WD-1:0] dout
);

    assign dout = WD'(sat_shl(32'(signed'(din)), sh, WD));

endmodule

// File: rtl/f7_bias_loader.sv
// Fetches NUM f7 bias words from the bias memory and streams them to the
// accumulator stage. Optional F7_BIAS_SHIFT_EN adds shift/saturate on capture.
//
// state | meaning
// IDLE  | waiting for i_start
// RD    | read strobe for the current index
// WAIT  | memory latency, word captured on the last cycle
// VLD   | bias presented until the consumer takes it
// DONE  | one-cycle completion pulse
module f7_bias_loader
    import f7_bias_loader_pkg::*;
#(
    parameter int WD     = 8,
    parameter int NUM    = 10,
    parameter int AW     = 8,
    parameter int BASE   = 0,
    parameter int RD_LAT = 1
) (
    input  logic                 i_sclk,
    input  logic                 i_rstn,
    input  logic                 i_start,
    input  logic                 i_clear,
    output logic                 o_busy,
    output logic                 o_done,
    input  logic [2:0]           i_shift,
    f7_bias_loader_if.master     bus
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);
    localparam logic [7:0] LAST_IDX = 8'(NUM - 1);

    f7_state_e     state;
    f7_state_e     state_nxt;
    logic [7:0]    idx;
    logic [2:0]    lat_cnt;
    logic [WD-1:0] word;
    logic [WD-1:0] cap_word;
    logic          xfer;

`ifdef F7_BIAS_SHIFT_EN
    f7_bias_sat #(.WD(WD)) u_sat (
        .din  (bus.i_rd_data),
        .sh   (i_shift),
        .dout (cap_word)
    );
`else
    logic unused_shift;
    assign unused_shift = ^i_shift;
    assign cap_word     = bus.i_rd_data;
`endif

    assign xfer = (state == ST_VLD) && bus.i_ready;

    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (i_start) state_nxt = ST_RD;
                ST_RD:   state_nxt = ST_WAIT;
                ST_WAIT: if (lat_cnt == 3'd0) state_nxt = ST_VLD;
                ST_VLD:  if (xfer) state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_RD;
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Index, latency down-counter and held word; clear discards any read in flight.
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            idx     <= 8'd0;
            lat_cnt <= 3'd0;
            word    <= '0;
        end else if (i_clear) begin
            idx     <= 8'd0;
            lat_cnt <= 3'd0;
            word    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (i_start) idx <= 8'd0;
                ST_RD:   lat_cnt <= LAT_LOAD;
                ST_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        word <= cap_word;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ST_VLD:  if (xfer && (idx != LAST_IDX)) idx <= idx + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy        = (state != ST_IDLE);
        o_done        = (state == ST_DONE);
        bus.o_rd_en   = (state == ST_RD);
        bus.o_rd_addr = (state == ST_RD) ? (AW'(BASE) + AW'(idx)) : '0;
        bus.o_bias_en = (state == ST_VLD);
        bus.o_b_num   = (state == ST_VLD) ? (idx + 8'd1) : 8'd0;
        bus.o_bias    = word;
    end

endmodule

// File: tb/tb_f7_bias_loader.sv
// Scoreboard bench: two loaders (RD_LAT=1 and RD_LAT=3 with wrapping base) fed by
// latency-accurate memory models; a negedge monitor checks every transfer.
module tb_f7_bias_loader;
    localparam int WD     = 8;
    localparam int AW     = 8;
    localparam int NUM_A  = 10;
    localparam int LAT_A  = 1;
    localparam int BASE_A = 0;
    localparam int NUM_B  = 6;
    localparam int LAT_B  = 3;
    localparam int BASE_B = 252;

    typedef struct {
        int num;
        int bias;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, clear_a = 1'b0, ready_a = 1'b1;
    logic       start_b = 1'b0, clear_b = 1'b0, ready_b = 1'b1;
    logic       busy_a, done_a, busy_b, done_b;
    logic [2:0] shift = 3'd2;

    f7_bias_loader_if #(.WD(WD), .AW(AW)) bus_a ();
    f7_bias_loader_if #(.WD(WD), .AW(AW)) bus_b ();

    f7_bias_loader #(.WD(WD), .NUM(NUM_A), .AW(AW), .BASE(BASE_A), .RD_LAT(LAT_A)) dut_a (
        .i_sclk(clk), .i_rstn(rst_n), .i_start(start_a), .i_clear(clear_a),
        .o_busy(busy_a), .o_done(done_a), .i_shift(shift), .bus(bus_a)
    );

    f7_bias_loader #(.WD(WD), .NUM(NUM_B), .AW(AW), .BASE(BASE_B), .RD_LAT(LAT_B)) dut_b (
        .i_sclk(clk), .i_rstn(rst_n), .i_start(start_b), .i_clear(clear_b),
        .o_busy(busy_b), .o_done(done_b), .i_shift(shift), .bus(bus_b)
    );

    // Memory models: data appears exactly RD_LAT cycles after the strobe, noise otherwise.
    logic [WD-1:0] mem_a [256];
    logic [WD-1:0] mem_b [256];
    logic [WD-1:0] pipe_a [LAT_A];
    logic [WD-1:0] pipe_b [LAT_B];

    always @(posedge clk) begin
        pipe_a[0] <= bus_a.o_rd_en ? mem_a[bus_a.o_rd_addr] : WD'($urandom);
        for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
        pipe_b[0] <= bus_b.o_rd_en ? mem_b[bus_b.o_rd_addr] : WD'($urandom);
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end

    assign bus_a.i_rd_data = pipe_a[LAT_A-1];
    assign bus_b.i_rd_data = pipe_b[LAT_B-1];
    assign bus_a.i_ready   = ready_a;
    assign bus_b.i_ready   = ready_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   rd_cnt [2] = '{0, 0};
    int   rd_ref [2] = '{0, 0};
    int   last_xfer [2] = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    int   done_cyc [2] = '{0, 0};
    logic prev_en [2] = '{1'b0, 1'b0};
    int   prev_num [2] = '{0, 0};
    int   prev_bias [2] = '{0, 0};

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: signed word, optionally scaled by 2**shift and clamped to WD bits.
    function automatic int model_bias(input logic [WD-1:0] w);
        int v;
        v = int'($signed(w));
`ifdef F7_BIAS_SHIFT_EN
        v = v * (2 ** int'(shift));
        if (v > 2 ** (WD - 1) - 1) v = 2 ** (WD - 1) - 1;
        if (v < -(2 ** (WD - 1))) v = -(2 ** (WD - 1));
`endif
        return v;
    endfunction

    task automatic mon_step(input int u, input logic en, input logic rdy, input logic clr,
                            input logic [7:0] num, input logic [WD-1:0] bias,
                            input logic rd, input logic [AW-1:0] addr, input logic done);
        exp_t  e;
        logic  have;
        string p;
        int    base, lat, num_runs;
        p        = (u == 0) ? "a" : "b";
        base     = (u == 0) ? BASE_A : BASE_B;
        lat      = (u == 0) ? LAT_A : LAT_B;
        num_runs = (u == 0) ? NUM_A : NUM_B;
        if (rd) begin
            check({p, "_rd_addr"}, int'(addr), (base + rd_cnt[u]) % 256);
            rd_cnt[u]++;
        end
        if (en) begin
            if (!prev_en[u]) begin
                check({p, "_vld_time"}, cyc, rd_ref[u] + 1 + lat);
            end else begin
                check({p, "_hold_num"}, int'(num), prev_num[u]);
                check({p, "_hold_bias"}, int'(bias), prev_bias[u]);
            end
            if (rdy && !clr) begin
                have = 1'b0;
                if (u == 0 && qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
                if (u == 1 && qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
                if (!have) begin
                    check({p, "_unexpected_xfer"}, 1, 0);
                end else begin
                    check({p, "_b_num"}, int'(num), e.num);
                    check({p, "_bias"}, int'($signed(bias)), e.bias);
                end
                last_xfer[u] = cyc;
                rd_ref[u]    = cyc + 1;
            end
        end else begin
            check({p, "_b_num_idle"}, int'(num), 0);
        end
        if (done) begin
            check({p, "_done_time"}, cyc, last_xfer[u] + 1);
            check({p, "_done_left"}, (u == 0) ? qa.size() : qb.size(), 0);
            check({p, "_done_reads"}, rd_cnt[u], num_runs);
            done_cnt[u]++;
            done_cyc[u] = cyc;
        end
        prev_en[u]   = en;
        prev_num[u]  = int'(num);
        prev_bias[u] = int'(bias);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_step(0, bus_a.o_bias_en, bus_a.i_ready, clear_a, bus_a.o_b_num, bus_a.o_bias,
                     bus_a.o_rd_en, bus_a.o_rd_addr, done_a);
            mon_step(1, bus_b.o_bias_en, bus_b.i_ready, clear_b, bus_b.o_b_num, bus_b.o_bias,
                     bus_b.o_rd_en, bus_b.o_rd_addr, done_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int u);
        exp_t e;
        int   n = (u == 0) ? NUM_A : NUM_B;
        for (int i = 0; i < n; i++) begin
            e.num = i + 1;
            if (u == 0) begin
                e.bias = model_bias(mem_a[(BASE_A + i) % 256]);
                qa.push_back(e);
            end else begin
                e.bias = model_bias(mem_b[(BASE_B + i) % 256]);
                qb.push_back(e);
            end
        end
        rd_cnt[u] = 0;
        rd_ref[u] = cyc + 1;
        if (u == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int u, input bit rnd_ready, input int budget);
        int d0 = done_cnt[u];
        int n  = 0;
        while (done_cnt[u] == d0 && n < budget) begin
            if (u == 0) ready_a = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            else        ready_b = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        ready_a = 1'b1;
        ready_b = 1'b1;
        check((u == 0) ? "a_wait_done" : "b_wait_done", int'(done_cnt[u] != d0), 1);
    endtask

    task automatic wait_num_a(input int num, input int budget);
        int n = 0;
        while (!(bus_a.o_bias_en && int'(bus_a.o_b_num) == num) && n < budget) begin
            tick();
            n++;
        end
        check("a_wait_num", int'(n < budget), 1);
    endtask

    initial begin
        int s;
        int n;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = WD'($urandom);
            mem_b[i] = WD'($urandom);
        end
        for (int i = 0; i < 10; i++) mem_a[i] = WD'(i + 1);

        repeat (3) tick();
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_rd_en", int'(bus_a.o_rd_en), 0);
        check("rst_rd_addr", int'(bus_a.o_rd_addr), 0);
        check("rst_bias_en", int'(bus_a.o_bias_en), 0);
        check("rst_b_num", int'(bus_a.o_b_num), 0);
        check("rst_bias", int'(bus_a.o_bias), 0);
        check("rst_busy_b", int'(busy_b), 0);
        rst_n = 1'b1;
        tick();

        // Full run with ready held high: 3 cycles per bias.
        start_run(0);
        s = rd_ref[0];
        check("a_busy_run", int'(busy_a), 1);
        wait_done(0, 1'b0, 200);
        check("a_run_length", done_cyc[0] - s, NUM_A * (2 + LAT_A));
        check("a_busy_after", int'(busy_a), 0);

        // Consumer stall on neuron 4.
        start_run(0);
        wait_num_a(3, 100);
        tick();
        ready_a = 1'b0;
        repeat (7) tick();
        check("a_stall_num", int'(bus_a.o_b_num), 4);
        ready_a = 1'b1;
        wait_done(0, 1'b0, 200);
        check("a_final_bias", int'(bus_a.o_bias), model_bias(mem_a[9]));

        // Clear during the WAIT of neuron 6, then restart with random ready.
        for (int i = 0; i < 256; i++) mem_a[i] = WD'($urandom);
        start_run(0);
        n = 0;
        while (!(bus_a.o_rd_en && int'(bus_a.o_rd_addr) == BASE_A + 5) && n < 100) begin
            tick();
            n++;
        end
        check("a_wait_rd6", int'(n < 100), 1);
        tick();
        clear_a = 1'b1;
        qa.delete();
        tick();
        clear_a = 1'b0;
        check("a_clear_busy", int'(busy_a), 0);
        check("a_clear_bias", int'(bus_a.o_bias), 0);
        repeat (4) tick();
        check("a_clear_idle", int'(busy_a), 0);
        start_run(0);
        wait_done(0, 1'b1, 400);

        // Mid-run start ignored; start coincident with clear during VLD of neuron 6.
        start_run(0);
        wait_num_a(3, 100);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_num_a(6, 100);
        clear_a = 1'b1;
        start_a = 1'b1;
        qa.delete();
        tick();
        clear_a = 1'b0;
        start_a = 1'b0;
        check("a_clr_start_busy", int'(busy_a), 0);
        repeat (5) begin
            tick();
            check("a_no_restart_rd", int'(bus_a.o_rd_en), 0);
            check("a_no_restart_busy", int'(busy_a), 0);
        end

        // Shift/saturate vectors (identity in the default build).
        mem_a[0] = 8'd20;
        mem_a[1] = 8'd40;
        mem_a[2] = 8'hD8;
        mem_a[3] = 8'hFD;
        start_run(0);
        wait_done(0, 1'b0, 200);

        // Long latency with address wrap.
        start_run(1);
        s = rd_ref[1];
        wait_done(1, 1'b0, 300);
        check("b_run_length", done_cyc[1] - s, NUM_B * (2 + LAT_B));
        for (int i = 0; i < 256; i++) mem_b[i] = WD'($urandom);
        start_run(1);
        wait_done(1, 1'b1, 600);

        tick();
        check("a_done_total", done_cnt[0], 4);
        check("b_done_total", done_cnt[1], 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
